// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into SEG-bit ripple segments, one per pipeline stage
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_valid/ready   operand beat handshake (a, b, sub)
//   a, b             WIDTH-bit operands
//   sub              0: a+b, 1: a-b
//   out_valid/ready  result beat handshake (sum, cout, overflow)
//   sum              WIDTH-bit result, modulo 2^WIDTH
//   cout             carry out of the MSB (for subtract, 1 means no borrow)
//   overflow         signed overflow
module pipelined_addsub #(
    parameter int WIDTH = 49,
    parameter int SEG   = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NSEG = (WIDTH + SEG - 1) / SEG;

    logic [NSEG-1:0] r_v;
    logic [NSEG-1:0] w_adv;
    logic [NSEG-1:0] w_vin;

    assign in_ready  = w_adv[0];
    assign out_valid = r_v[NSEG-1];

    always_ff @(posedge clk) begin
        if (rst) r_v <= '0;
        else     r_v <= (w_adv & w_vin) | (~w_adv & r_v);
    end

    genvar k;
    for (k = 0; k < NSEG; k++) begin : g
        localparam int LO = k * SEG;
        localparam int HI = (k == NSEG - 1) ? WIDTH - 1 : LO + SEG - 1;
        localparam int SW = HI - LO + 1;

        logic [WIDTH-1:LO] w_a;
        logic [WIDTH-1:LO] w_b;
        logic              w_ci;
        logic [HI:0]       w_s;
        logic              w_co;

        // A stage moves whenever some stage at or after it is empty, or the
        // sink is taking a result; written flat so the ready chain has no loop.
        assign w_adv[k] = out_ready || !(&r_v[NSEG-1:k]);

        if (k == 0) begin : g_in
            assign w_vin[k] = in_valid;
            assign w_a      = a;
            assign w_b      = b ^ {WIDTH{sub}};
            assign w_ci     = sub;
        end else begin : g_in
            assign w_vin[k]       = r_v[k-1];
            assign w_a            = g[k-1].g_mid.r_a;
            assign w_b            = g[k-1].g_mid.r_b;
            assign w_ci           = g[k-1].g_mid.r_c;
            assign w_s[LO-1:0]    = g[k-1].g_mid.r_s;
        end

        assign {w_co, w_s[HI:LO]} = {1'b0, w_a[HI:LO]} + {1'b0, w_b[HI:LO]} + {{SW{1'b0}}, w_ci};

        if (k < NSEG - 1) begin : g_mid
            // Operand bits still to be added ride ahead (skew); finished
            // result bits ride along (de-skew).
            logic [WIDTH-1:HI+1] r_a;
            logic [WIDTH-1:HI+1] r_b;
            logic [HI:0]         r_s;
            logic                r_c;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_s <= '0;
                    r_c <= 1'b0;
                end else if (w_adv[k] && w_vin[k]) begin
                    r_a <= w_a[WIDTH-1:HI+1];
                    r_b <= w_b[WIDTH-1:HI+1];
                    r_s <= w_s;
                    r_c <= w_co;
                end
            end
        end else begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum      <= '0;
                    cout     <= 1'b0;
                    overflow <= 1'b0;
                end else if (w_adv[k] && w_vin[k]) begin
                    sum      <= w_s;
                    cout     <= w_co;
                    overflow <= (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_s[WIDTH-1] != w_a[WIDTH-1]);
                end
            end
        end
    end
endmodule
